// File: rtl/valid_ack_arbiter.sv
// Two-requester round-robin arbiter onto one four-phase valid/ack channel.
// Every output is registered; reset assertion is asynchronous, its release is synchronised to clk.
module valid_ack_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    output logic          s0_ack,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    output logic          s1_ack,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ack,
    output logic          busy,
    output logic          grant,
    output logic [15:0]   xfer_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    logic [1:0]    rst_sync_r;
    logic          rst_sync_n_s;
    state_t        state_r, state_nxt_s;
    logic          win_s, any_req_s, g_valid_s;
    logic          m_valid_r, m_valid_nxt_s;
    logic [DW-1:0] m_data_r, m_data_nxt_s;
    logic          s0_ack_r, s0_ack_nxt_s;
    logic          s1_ack_r, s1_ack_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          grant_r, grant_nxt_s;
    logic          last_grant_r, last_grant_nxt_s;
    logic [15:0]   xfer_cnt_r, xfer_cnt_nxt_s;

    // Reset synchroniser: asserts immediately, releases after two clk edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_sync_n_s = rst_sync_r[1];
    assign any_req_s    = s0_valid | s1_valid;
    assign g_valid_s    = grant_r ? s1_valid : s0_valid;

    // Round-robin winner: on contention the requester not served last wins.
    always_comb begin
        win_s = 1'b0;
        if (s0_valid && s1_valid) begin
            win_s = ~last_grant_r;
        end else if (s1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    state_nxt_s = any_req_s ? ST_SEND : ST_IDLE;
            ST_SEND:    state_nxt_s = m_ack ? ST_RELEASE : ST_SEND;
            ST_RELEASE: state_nxt_s = (!m_ack && !g_valid_s) ? ST_IDLE : ST_RELEASE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        m_valid_nxt_s    = m_valid_r;
        m_data_nxt_s     = m_data_r;
        s0_ack_nxt_s     = s0_ack_r;
        s1_ack_nxt_s     = s1_ack_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        xfer_cnt_nxt_s   = xfer_cnt_r;
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    m_valid_nxt_s = 1'b1;
                    m_data_nxt_s  = win_s ? s1_data : s0_data;
                    grant_nxt_s   = win_s;
                end else begin
                    m_valid_nxt_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (m_ack) begin
                    m_valid_nxt_s = 1'b0;
                    s0_ack_nxt_s  = ~grant_r;
                    s1_ack_nxt_s  = grant_r;
                end else begin
                    m_valid_nxt_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!m_ack && !g_valid_s) begin
                    s0_ack_nxt_s     = 1'b0;
                    s1_ack_nxt_s     = 1'b0;
                    last_grant_nxt_s = grant_r;
                    xfer_cnt_nxt_s   = xfer_cnt_r + 16'd1;
                end else begin
                    m_valid_nxt_s = 1'b0;
                end
            end
            default: begin
                m_valid_nxt_s = 1'b0;
                s0_ack_nxt_s  = 1'b0;
                s1_ack_nxt_s  = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            m_valid_r    <= 1'b0;
            m_data_r     <= {DW{1'b0}};
            s0_ack_r     <= 1'b0;
            s1_ack_r     <= 1'b0;
            busy_r       <= 1'b0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            xfer_cnt_r   <= 16'd0;
        end else begin
            m_valid_r    <= m_valid_nxt_s;
            m_data_r     <= m_data_nxt_s;
            s0_ack_r     <= s0_ack_nxt_s;
            s1_ack_r     <= s1_ack_nxt_s;
            busy_r       <= busy_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            xfer_cnt_r   <= xfer_cnt_nxt_s;
        end
    end

    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign s0_ack   = s0_ack_r;
    assign s1_ack   = s1_ack_r;
    assign busy     = busy_r;
    assign grant    = grant_r;
    assign xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_valid_ack_arbiter.sv
// Directed self-checking bench for valid_ack_arbiter with hand-computed expectations.
module tb_valid_ack_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0, m_ack = 1'b0;
    logic [7:0]  s0_data = 8'h00, s1_data = 8'h00;
    logic        s0_ack, s1_ack, m_valid, busy, grant;
    logic [7:0]  m_data;
    logic [15:0] xfer_cnt;
    logic [15:0] exp_cnt = 16'd0;
    int          n_checks = 0;
    int          n_pass = 0;

    valid_ack_arbiter #(.DW(8)) dut (
        .clk(clk), .rstn(rstn),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ack(s0_ack),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ack(s1_ack),
        .m_valid(m_valid), .m_data(m_data), .m_ack(m_ack),
        .busy(busy), .grant(grant), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
        chk({tag, "_s0ack"}, 32'(s0_ack), 32'd0);
        chk({tag, "_s1ack"}, 32'(s1_ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One full four-phase transfer; requester valids must already be set up.
    task automatic xfer(input logic g, input logic [7:0] d, input logic reraise);
        tick();
        chk("send_mvalid", 32'(m_valid), 32'd1);
        chk("send_mdata", 32'(m_data), 32'(d));
        chk("send_grant", 32'(grant), 32'(g));
        chk("send_busy", 32'(busy), 32'd1);
        chk("send_acks", 32'({s1_ack, s0_ack}), 32'd0);
        m_ack = 1'b1;
        tick();
        chk("rel_mvalid", 32'(m_valid), 32'd0);
        chk("rel_acks", 32'({s1_ack, s0_ack}), g ? 32'd2 : 32'd1);
        chk("rel_busy", 32'(busy), 32'd1);
        m_ack = 1'b0;
        if (g) s1_valid = 1'b0; else s0_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("done_acks", 32'({s1_ack, s0_ack}), 32'd0);
        chk("done_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        chk("done_busy", 32'(busy), 32'd0);
        if (reraise) begin
            if (g) s1_valid = 1'b1; else s0_valid = 1'b1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk_idle_outputs("rst");
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);
        exp_cnt = 16'd0;
        tick();
        rstn = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        // Power-on reset
        tick();
        do_reset();

        // Single request from requester 0
        s0_valid = 1'b1; s0_data = 8'hA1;
        xfer(1'b0, 8'hA1, 1'b0);

        // m_ack in IDLE is ignored
        m_ack = 1'b1;
        tick();
        chk_idle_outputs("idle_mack");
        chk("idle_mack_cnt", 32'(xfer_cnt), 32'd1);
        m_ack = 1'b0;
        tick();

        // Simultaneous requests from reset: requester 0 first
        do_reset();
        s0_valid = 1'b1; s0_data = 8'hB2;
        s1_valid = 1'b1; s1_data = 8'hD8;
        xfer(1'b0, 8'hB2, 1'b0);
        xfer(1'b1, 8'hD8, 1'b0);

        // Fairness: both held, grants alternate 0,1,0,1
        s0_valid = 1'b1; s0_data = 8'h11;
        s1_valid = 1'b1; s1_data = 8'h22;
        xfer(1'b0, 8'h11, 1'b1);
        xfer(1'b1, 8'h22, 1'b1);
        xfer(1'b0, 8'h11, 1'b1);
        xfer(1'b1, 8'h22, 1'b0);
        s0_valid = 1'b0;
        tick();

        // Stalled downstream; data change and early valid drop mid-SEND
        s0_valid = 1'b1; s0_data = 8'hFF;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                s0_data = 8'h00;
                s0_valid = 1'b0;
            end
            tick();
            chk("stall_mvalid", 32'(m_valid), 32'd1);
            chk("stall_mdata", 32'(m_data), 32'hFF);
            chk("stall_s0ack", 32'(s0_ack), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        m_ack = 1'b1;
        tick();
        chk("stall_ack", 32'(s0_ack), 32'd1);
        m_ack = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("stall_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        chk("stall_done_busy", 32'(busy), 32'd0);

        // Reset mid-SEND abandons the transfer
        s0_valid = 1'b1; s0_data = 8'hC9;
        tick();
        chk("pre_rst_mdata", 32'(m_data), 32'hC9);
        #2;
        rstn = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_mdata", 32'(m_data), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_cnt", 32'(xfer_cnt), 32'd0);
        exp_cnt = 16'd0;
        s0_valid = 1'b0;
        s1_valid = 1'b1; s1_data = 8'h5A;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("sync_hold_busy", 32'(busy), 32'd0);
        xfer(1'b1, 8'h5A, 1'b0);

        // Counter wrap from 16'hFFFF
        tick();
        force dut.xfer_cnt_r = 16'hFFFF;
        #1;
        release dut.xfer_cnt_r;
        exp_cnt = 16'hFFFF;
        s0_valid = 1'b1; s0_data = 8'h3C;
        xfer(1'b0, 8'h3C, 1'b0);
        chk("wrap_zero", 32'(xfer_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
